// File: rtl/motion_pkg.sv
// Shared types and screen constants for per-character motion blocks.
package motion_pkg;

  typedef enum logic [1:0] {
    MS_GROUND = 2'd0,
    MS_RISE   = 2'd1,
    MS_FALL   = 2'd2
  } motion_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned POS_W    = 10;

endpackage

// File: rtl/character_motion_ctrl_frame_tick_gen.sv
// Per-frame update strobe: one-cycle registered pulse after the scan
// reaches the first pixel of the chosen line.
module frame_tick_gen
  import motion_pkg::*;
#(
  parameter int unsigned UPDATE_LINE = SCREEN_H
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [POS_W-1:0] draw_x,
  input  logic [POS_W-1:0] draw_y,
  output logic             frame_tick
);

  logic frame_tick_d, frame_tick_q;

  // Detect the update scan position.
  always_comb begin
    frame_tick_d = (draw_x == '0) && (draw_y == POS_W'(UPDATE_LINE));
  end

  // Register the strobe so it is glitch-free and one cycle wide.
  always_ff @(posedge clk) begin
    if (!reset_n) frame_tick_q <= 1'b0;
    else          frame_tick_q <= frame_tick_d;
  end

  assign frame_tick = frame_tick_q;

endmodule

// File: rtl/character_motion_ctrl.sv
// Per-character motion engine: buttons + collision flags -> sprite centre,
// updated once per frame during vblank.
module character_motion_ctrl
  import motion_pkg::*;
#(
  parameter int START_X     = 100,
  parameter int START_Y     = 427,
  parameter int HALF_W      = 10,
  parameter int HALF_H      = 13,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = SCREEN_W - 1,
  parameter int FLOOR_Y     = 440,
  parameter int WALK_STEP   = 2,
  parameter int JUMP_V0     = 8,
  parameter int GRAVITY     = 1,
  parameter int VMAX        = 8,
  parameter int UPDATE_LINE = SCREEN_H
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               jump,
  input  logic               solid_below,
  input  logic               solid_above,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic signed [5:0]  vel_y,
  output motion_state_t      state,
  output logic               facing_left,
  output logic               frame_tick
);

  localparam logic signed [10:0] X_LO_S   = 11'(X_MIN + HALF_W);
  localparam logic signed [10:0] X_HI_S   = 11'(X_MAX - HALF_W);
  localparam logic signed [10:0] HALF_H_S = 11'(HALF_H);
  localparam logic signed [10:0] FLOOR_S  = 11'(FLOOR_Y);
  localparam logic signed [10:0] REST_Y_S = 11'(FLOOR_Y - HALF_H);
  localparam logic signed [10:0] STEP_S   = 11'(WALK_STEP);
  localparam logic signed [10:0] JV0_S    = 11'(JUMP_V0);
  localparam logic signed [10:0] GRAV_S   = 11'(GRAVITY);
  localparam logic signed [10:0] VMAX_S   = 11'(VMAX);

  logic [9:0]         pos_x_d, pos_x_q;
  logic [9:0]         pos_y_d, pos_y_q;
  logic signed [5:0]  vel_y_d, vel_y_q;
  motion_state_t      state_d, state_q;
  logic               facing_left_d, facing_left_q;
  logic               jump_prev_d, jump_prev_q;

  logic signed [10:0] x_s, y_s, vel_s, vel_next, y_next, vel_fall, y_fall, x_new;
  logic               jump_edge;

  frame_tick_gen #(
    .UPDATE_LINE (UPDATE_LINE)
  ) u_tick (
    .clk        (vga_clk),
    .reset_n    (reset_n),
    .draw_x     (DrawX),
    .draw_y     (DrawY),
    .frame_tick (frame_tick)
  );

  // Next-state: horizontal walk/clamp and vertical jump/fall FSM, applied on the tick only.
  always_comb begin
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    vel_y_d       = vel_y_q;
    state_d       = state_q;
    facing_left_d = facing_left_q;
    jump_prev_d   = jump_prev_q;

    x_s       = signed'({1'b0, pos_x_q});
    y_s       = signed'({1'b0, pos_y_q});
    vel_s     = {{5{vel_y_q[5]}}, vel_y_q};
    vel_next  = vel_s + GRAV_S;
    y_next    = y_s + vel_next;
    vel_fall  = (vel_next > VMAX_S) ? VMAX_S : vel_next;
    y_fall    = y_s + vel_fall;
    jump_edge = jump & ~jump_prev_q;

    x_new = x_s;
    if (move_left && !move_right)      x_new = x_s - STEP_S;
    else if (move_right && !move_left) x_new = x_s + STEP_S;
    if (x_new < X_LO_S)      x_new = X_LO_S;
    else if (x_new > X_HI_S) x_new = X_HI_S;

    if (frame_tick) begin
      pos_x_d     = x_new[9:0];
      jump_prev_d = jump;
      if (move_left && !move_right)      facing_left_d = 1'b1;
      else if (move_right && !move_left) facing_left_d = 1'b0;

      case (state_q)
        MS_GROUND: begin
          if (jump_edge) begin
            vel_y_d = 6'(-JV0_S);
            pos_y_d = 10'(y_s - JV0_S);
            state_d = MS_RISE;
          end else if (!solid_below && (y_s + HALF_H_S < FLOOR_S)) begin
            vel_y_d = '0;
            state_d = MS_FALL;
          end
        end
        MS_RISE: begin
          if (solid_above) begin
            vel_y_d = '0;
            state_d = MS_FALL;
          end else if (y_next < HALF_H_S) begin
            pos_y_d = 10'(HALF_H_S);
            vel_y_d = '0;
            state_d = MS_FALL;
          end else begin
            pos_y_d = 10'(y_next);
            vel_y_d = 6'(vel_next);
            if (!vel_next[10]) state_d = MS_FALL;
          end
        end
        MS_FALL: begin
          // Floor snap takes priority over a platform hit on the same tick.
          if (y_fall + HALF_H_S >= FLOOR_S) begin
            pos_y_d = 10'(REST_Y_S);
            vel_y_d = '0;
            state_d = MS_GROUND;
          end else if (solid_below) begin
            vel_y_d = '0;
            state_d = MS_GROUND;
          end else begin
            pos_y_d = 10'(y_fall);
            vel_y_d = 6'(vel_fall);
          end
        end
        default: begin
          vel_y_d = '0;
          state_d = MS_FALL;
        end
      endcase
    end
  end

  // State and position registers with synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      pos_x_q       <= 10'(START_X);
      pos_y_q       <= 10'(START_Y);
      vel_y_q       <= '0;
      state_q       <= MS_GROUND;
      facing_left_q <= 1'b0;
      jump_prev_q   <= 1'b0;
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vel_y_q       <= vel_y_d;
      state_q       <= state_d;
      facing_left_q <= facing_left_d;
      jump_prev_q   <= jump_prev_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign vel_y       = vel_y_q;
  assign state       = state_q;
  assign facing_left = facing_left_q;

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Scoreboard bench for character_motion_ctrl: expected per-tick results are
// queued by the stimulus and checked by a monitor after each frame update.
module tb_character_motion_ctrl;
  import motion_pkg::*;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic [9:0]        DrawX, DrawY;
  logic              move_left, move_right, jump, solid_below, solid_above;
  logic [9:0]        pos_x, pos_y;
  logic signed [5:0] vel_y;
  motion_state_t     state;
  logic              facing_left, frame_tick;

  always #5 vga_clk = ~vga_clk;

  character_motion_ctrl dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .move_left   (move_left),
    .move_right  (move_right),
    .jump        (jump),
    .solid_below (solid_below),
    .solid_above (solid_above),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .vel_y       (vel_y),
    .state       (state),
    .facing_left (facing_left),
    .frame_tick  (frame_tick)
  );

  typedef struct {
    string         tag;
    int            x;
    int            y;
    int            v;
    motion_state_t st;
    bit            f;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   armed  = 0;

  // Shortened scan: 8 pixels x lines 479..481, so one frame is 24 cycles.
  initial begin
    DrawX = '0;
    DrawY = 10'd479;
    forever begin
      @(negedge vga_clk);
      if (DrawX == 10'd7) begin
        DrawX = '0;
        DrawY = (DrawY == 10'd481) ? 10'd479 : DrawY + 10'd1;
      end else begin
        DrawX = DrawX + 10'd1;
      end
    end
  end

  task automatic check_out(input exp_t e);
    checks++;
    if (pos_x !== 10'(e.x) || pos_y !== 10'(e.y) || vel_y !== 6'(e.v) ||
        state !== e.st || facing_left !== e.f) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d vel=%0d st=%0d face=%0b, want x=%0d y=%0d vel=%0d st=%0d face=%0b",
               e.tag, pos_x, pos_y, vel_y, state, facing_left, e.x, e.y, e.v, e.st, e.f);
    end
  endtask

  // Monitor: outputs are valid on the negedge following a tick cycle.
  initial forever begin
    @(negedge vga_clk);
    if (armed) begin
      armed = 0;
      if (q.size() > 0) check_out(q.pop_front());
    end
    if (frame_tick === 1'b1 && reset_n === 1'b1) armed = 1;
  end

  task automatic set_in(input bit l, input bit r, input bit j, input bit sb, input bit sa);
    move_left   = l;
    move_right  = r;
    jump        = j;
    solid_below = sb;
    solid_above = sa;
  endtask

  task automatic frame(input string tag, input int x, input int y, input int v,
                       input motion_state_t st, input bit f);
    exp_t e;
    bit   got;
    e.tag = tag; e.x = x; e.y = y; e.v = v; e.st = st; e.f = f;
    q.push_back(e);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge vga_clk);
      if (frame_tick === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_tick_timeout: got no frame_tick in 100 cycles, want one per 24", tag);
      void'(q.pop_back());
    end else begin
      @(negedge vga_clk);
    end
  endtask

  task automatic reset_and_check(input string tag, input int cycles);
    exp_t e;
    reset_n = 1'b0;
    repeat (cycles) @(negedge vga_clk);
    e.tag = tag; e.x = 100; e.y = 427; e.v = 0; e.st = MS_GROUND; e.f = 0;
    check_out(e);
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s_tick: got frame_tick=%0b, want 0", tag, frame_tick);
    end
    set_in(0, 0, 0, 1, 0);
    reset_n = 1'b1;
  endtask

  // Jump arc from ground (x=100): y, vel, state, jump, solid_below.
  int            ja_y [20] = '{419, 412, 406, 401, 397, 394, 392, 391, 391, 392,
                               394, 397, 401, 406, 412, 419, 427, 427, 427, 427};
  int            ja_v [20] = '{-8, -7, -6, -5, -4, -3, -2, -1, 0, 1,
                               2, 3, 4, 5, 6, 7, 0, 0, 0, 0};
  motion_state_t ja_s [20] = '{MS_RISE, MS_RISE, MS_RISE, MS_RISE, MS_RISE, MS_RISE, MS_RISE,
                               MS_RISE, MS_FALL, MS_FALL, MS_FALL, MS_FALL, MS_FALL, MS_FALL,
                               MS_FALL, MS_FALL, MS_GROUND, MS_GROUND, MS_GROUND, MS_GROUND};
  bit            ja_j [20] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit            ja_b [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  // Platform interactions: y, vel, state, jump, solid_below, solid_above.
  int            pa_y [14] = '{419, 412, 412, 413, 415, 415, 415, 415, 416, 418, 421, 425, 427, 427};
  int            pa_v [14] = '{-8, -7, 0, 1, 2, 0, 0, 0, 1, 2, 3, 4, 0, 0};
  motion_state_t pa_s [14] = '{MS_RISE, MS_RISE, MS_FALL, MS_FALL, MS_FALL, MS_GROUND, MS_GROUND,
                               MS_FALL, MS_FALL, MS_FALL, MS_FALL, MS_FALL, MS_GROUND, MS_GROUND};
  bit            pa_j [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit            pa_b [14] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
  bit            pa_a [14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int   ex;
    int   cnt;
    exp_t e;

    set_in(0, 0, 0, 1, 0);
    reset_and_check("reset", 3);

    // One tick per 24-cycle frame.
    cnt = 0;
    repeat (72) begin
      @(negedge vga_clk);
      if (frame_tick === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 3) begin
      errors++;
      $display("FAIL tick_rate: got %0d ticks in 72 cycles, want 3", cnt);
    end

    // Walking right, then both buttons, then a single left step and idle.
    set_in(0, 1, 0, 1, 0);
    for (int k = 1; k <= 10; k++) frame($sformatf("walk_r%0d", k), 100 + 2 * k, 427, 0, MS_GROUND, 0);
    set_in(1, 1, 0, 1, 0);
    for (int k = 1; k <= 5; k++) frame($sformatf("both%0d", k), 120, 427, 0, MS_GROUND, 0);
    set_in(1, 0, 0, 1, 0);
    frame("left1", 118, 427, 0, MS_GROUND, 1);
    set_in(0, 0, 0, 1, 0);
    frame("idle1", 118, 427, 0, MS_GROUND, 1);

    // Clamp at the right edge (629) and the left edge (10).
    set_in(0, 1, 0, 1, 0);
    for (int k = 1; k <= 258; k++) begin
      ex = 118 + 2 * k;
      if (ex > 629) ex = 629;
      frame($sformatf("clamp_r%0d", k), ex, 427, 0, MS_GROUND, 0);
    end
    set_in(1, 0, 0, 1, 0);
    for (int k = 1; k <= 311; k++) begin
      ex = 629 - 2 * k;
      if (ex < 10) ex = 10;
      frame($sformatf("clamp_l%0d", k), ex, 427, 0, MS_GROUND, 1);
    end

    reset_and_check("reset2", 3);

    // Full jump arc with jump held through landing, then released.
    for (int k = 0; k < 20; k++) begin
      set_in(0, 0, ja_j[k], ja_b[k], 0);
      frame($sformatf("arc%0d", k + 1), 100, ja_y[k], ja_v[k], ja_s[k], 0);
    end

    // Ceiling bump, platform landing, walking off the platform.
    for (int k = 0; k < 14; k++) begin
      set_in(0, 0, pa_j[k], pa_b[k], pa_a[k]);
      frame($sformatf("plat%0d", k + 1), 100, pa_y[k], pa_v[k], pa_s[k], 0);
    end

    // Jump while walking left, then check inputs are ignored between ticks.
    set_in(1, 0, 1, 0, 0);
    frame("mid1", 98, 419, -8, MS_RISE, 1);
    frame("mid2", 96, 412, -7, MS_RISE, 1);
    frame("mid3", 94, 406, -6, MS_RISE, 1);
    frame("mid4", 92, 401, -5, MS_RISE, 1);
    repeat (5) begin
      @(negedge vga_clk);
      set_in(move_right, ~move_right, ~jump, ~solid_below, ~solid_above);
    end
    e.tag = "between_ticks"; e.x = 92; e.y = 401; e.v = -5; e.st = MS_RISE; e.f = 1;
    check_out(e);

    reset_and_check("reset_mid_jump", 1);

    repeat (60) @(negedge vga_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion by 5 ms, want finish");
    $fatal(1, "watchdog");
  end

endmodule
